lcv_div_seq: RTL and testbench
==============================

# lcv_div_seq

Sequential signed/unsigned integer divider. It is the inverse companion to the DSP multiply-accumulate blocks and produces one quotient bit per cycle using restoring division. Operands enter through a valid/ready handshake, and results leave through a second valid/ready handshake. It sits beside the MAC units in the execute datapath and serves divide/remainder operations that cannot map onto DSP slices.

## Interface
- `WIDTH`, default 32: operand, quotient and remainder width in bits. Must be ≥ 2.
- `clk` in, 1 bit: single clock, rising edge.
- `rst` in, 1 bit: synchronous, active-low reset. Sampled on `clk` rising edge; low means reset.
- `in_valid` in, 1 bit: an operand pair is offered.
- `in_ready` out, 1 bit: the divider can accept an operand pair.
- `in_a` in, `WIDTH` bits: dividend.
- `in_b` in, `WIDTH` bits: divisor.
- `in_signed` in, 1 bit: 1 means two's-complement operands; 0 means unsigned.
- `out_valid` out, 1 bit: result registers hold a valid result.
- `out_ready` in, 1 bit: the consumer accepts the result.
- `out_quot` out, `WIDTH` bits: quotient.
- `out_rem` out, `WIDTH` bits: remainder.
- `out_div_zero` out, 1 bit: the divisor was zero for this result.

## Operation
- FSM states:
  - IDLE: `in_ready`=1.
  - RUN: iterating.
  - FIX: sign/special-case fixup.
  - DONE: `out_valid`=1.
- Transitions:
  - IDLE→RUN on `in_valid`&&`in_ready`.
  - RUN→FIX after `WIDTH` iterations.
  - FIX→DONE unconditionally.
  - DONE→IDLE on `out_ready`.
- `in_ready` is combinational: (state==IDLE) && `rst`. No new operation is accepted while a result is pending or in flight.
- Accept edge, in a single cycle:
  - Latch the sign of each operand (signed mode only).
  - Latch magnitudes `|a|` and `|b|` as unsigned `WIDTH`-bit values. The magnitude of the most-negative value is 2^(WIDTH-1), which fits unsigned.
  - Clear the partial remainder and load the iteration counter with `WIDTH`-1.
- RUN, each cycle:
  - Shift {rem, quot} left by 1, bringing in the dividend MSB.
  - Compute trial = rem − `|b|` at `WIDTH`+1 bits.
  - If trial ≥ 0: rem ← trial and quotient LSB ← 1. Otherwise quotient LSB ← 0.
  - Decrement the counter. Leave RUN when the counter reaches 0.
- FIX applies these rules in priority order:
  - Divisor == 0: `out_quot` = all ones, `out_rem` = `in_a` unmodified, `out_div_zero`=1. This applies to both signed and unsigned modes.
  - Signed, `in_a` == most-negative, `in_b` == −1: `out_quot` = most-negative, `out_rem` = 0. This is the overflow case; no flag is raised.
  - Otherwise, signed division truncates toward zero:
    - The quotient is negated iff the operand signs differ.
    - The remainder is negated iff the dividend is negative.
    - The remainder sign follows the dividend.
  - Unsigned mode returns the raw quotient and remainder.
- Special cases run the full iteration, so latency does not depend on the data.
- Outputs are registered and held stable while `out_valid`&&!`out_ready`.

## Timing
- Reset (`rst`=0 at an edge) forces:
  - state = IDLE, `out_valid`=0.
  - `out_quot`=0, `out_rem`=0, `out_div_zero`=0.
  - Internal counter and remainder = 0.
  - `in_ready` reads 0 while `rst`=0.
- Reset mid-operation, in RUN/FIX/DONE, abandons the operation with no output. The first accept is possible in the cycle after `rst` returns high.
- Latency: with the accept at edge E0, `out_valid` rises after edge E0+`WIDTH`+1, i.e. `WIDTH`+1 cycles after acceptance.
- Result handshake completes at the edge where `out_valid`&&`out_ready`:
  - `out_valid` falls after that edge.
  - `in_ready` rises in the following cycle.
- Minimum issue interval is `WIDTH`+3 cycles.
- `out_ready` held high in advance: the result is consumed on the first DONE cycle.
- `in_valid` asserted while `in_ready`=0 is ignored and does not stall the divider. Operand inputs are sampled only on the accept edge.

## Test plan
- Signed 100 / 7, `WIDTH`=32 → `out_quot`=14, `out_rem`=2, `out_div_zero`=0. `out_valid` rises exactly 33 cycles after the accept.
- Signed −100 / 7 → `out_quot`=−14 (0xFFFFFFF2), `out_rem`=−2 (0xFFFFFFFE). Signed 100 / −7 → `out_quot`=−14, `out_rem`=2.
- Unsigned 0xFFFFFFFF / 2 → `out_quot`=0x7FFFFFFF, `out_rem`=1. The same operands in signed mode (−1 / 2) → `out_quot`=0, `out_rem`=0xFFFFFFFF.
- Divide by zero, signed 5 / 0 → `out_quot`=0xFFFFFFFF, `out_rem`=5, `out_div_zero`=1.
- Overflow, signed 0x80000000 / 0xFFFFFFFF → `out_quot`=0x80000000, `out_rem`=0, `out_div_zero`=0.
- Backpressure:
  - Hold `out_ready`=0 for 10 cycles after `out_valid`: outputs stay stable and `in_ready` stays 0 while `in_valid` is driven.
  - Then pulse `out_ready`: IDLE is re-entered and the next op is accepted.
- Reset mid-operation: assert `rst`=0 during RUN cycle 10 → the next cycle shows `out_valid`=0 and all outputs 0. The next op, 9 / 3, returns `out_quot`=3, `out_rem`=0.

Source files
------------

// File: rtl/lcv_div_seq_if.sv
`default_nettype none
// ---- lcv_div_seq_if : operand/result handshake bundle for lcv_div_seq -- rev 1.0 ----
interface lcv_div_seq_if #(
  parameter int WIDTH = 32
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_a;
  logic [WIDTH-1:0] in_b;
  logic             in_signed;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_quot;
  logic [WIDTH-1:0] out_rem;
  logic             out_div_zero;

  modport master (
    output in_valid, in_a, in_b, in_signed, out_ready,
    input  in_ready, out_valid, out_quot, out_rem, out_div_zero
  );

  modport slave (
    input  in_valid, in_a, in_b, in_signed, out_ready,
    output in_ready, out_valid, out_quot, out_rem, out_div_zero
  );
endinterface
`default_nettype wire

// File: rtl/lcv_div_seq.sv
`default_nettype none
// ---- lcv_div_seq : sequential restoring divider, one quotient bit per cycle -- rev 1.0 ----
module lcv_div_seq #(
  parameter int WIDTH = 32
) (
  input  logic          clk,
  input  logic          rst,
  lcv_div_seq_if.slave  bus
);

  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0]    CNT_INIT = CW'(WIDTH - 1);
  localparam logic [WIDTH-1:0] MOST_NEG = {1'b1, {(WIDTH-1){1'b0}}};
  localparam logic [WIDTH-1:0] ONE      = {{(WIDTH-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_FIX  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic [WIDTH-1:0] quot_q, quot_d;
  logic [WIDTH-1:0] bmag_q, bmag_d;
  logic [WIDTH-1:0] araw_q, araw_d;
  logic             sign_a_q, sign_a_d;
  logic             sign_b_q, sign_b_d;
  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] out_quot_q, out_quot_d;
  logic [WIDTH-1:0] out_rem_q, out_rem_d;
  logic             out_dz_q, out_dz_d;

  logic             in_ready;
  logic             a_neg, b_neg;
  logic [WIDTH:0]   shifted;
  logic [WIDTH+1:0] trial;
  logic             trial_ge;

  assign in_ready = (state_q == S_IDLE) && rst;
  assign a_neg    = bus.in_signed && bus.in_a[WIDTH-1];
  assign b_neg    = bus.in_signed && bus.in_b[WIDTH-1];

  // Trial subtraction is one bit wider than the shifted remainder so its MSB is the borrow.
  assign shifted  = {rem_q, quot_q[WIDTH-1]};
  assign trial    = {1'b0, shifted} - {2'b00, bmag_q};
  assign trial_ge = ~trial[WIDTH+1];

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    rem_d       = rem_q;
    quot_d      = quot_q;
    bmag_d      = bmag_q;
    araw_d      = araw_q;
    sign_a_d    = sign_a_q;
    sign_b_d    = sign_b_q;
    out_valid_d = out_valid_q;
    out_quot_d  = out_quot_q;
    out_rem_d   = out_rem_q;
    out_dz_d    = out_dz_q;

    case (state_q)
      S_IDLE: begin
        if (bus.in_valid && in_ready) begin
          sign_a_d = a_neg;
          sign_b_d = b_neg;
          quot_d   = a_neg ? (~bus.in_a + ONE) : bus.in_a;
          bmag_d   = b_neg ? (~bus.in_b + ONE) : bus.in_b;
          araw_d   = bus.in_a;
          rem_d    = '0;
          cnt_d    = CNT_INIT;
          state_d  = S_RUN;
        end
      end
      S_RUN: begin
        quot_d = {quot_q[WIDTH-2:0], trial_ge};
        rem_d  = trial_ge ? trial[WIDTH-1:0] : shifted[WIDTH-1:0];
        cnt_d  = cnt_q - CW'(1);
        if (cnt_q == '0) begin
          state_d = S_FIX;
        end
      end
      S_FIX: begin
        out_valid_d = 1'b1;
        out_dz_d    = 1'b0;
        if (bmag_q == '0) begin
          out_quot_d = '1;
          out_rem_d  = araw_q;
          out_dz_d   = 1'b1;
        end else if (sign_b_q && (araw_q == MOST_NEG) && (bmag_q == ONE)) begin
          out_quot_d = MOST_NEG;
          out_rem_d  = '0;
        end else begin
          out_quot_d = (sign_a_q ^ sign_b_q) ? (~quot_q + ONE) : quot_q;
          out_rem_d  = sign_a_q ? (~rem_q + ONE) : rem_q;
        end
        state_d = S_DONE;
      end
      S_DONE: begin
        if (bus.out_ready) begin
          out_valid_d = 1'b0;
          state_d     = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      rem_q       <= '0;
      quot_q      <= '0;
      bmag_q      <= '0;
      araw_q      <= '0;
      sign_a_q    <= 1'b0;
      sign_b_q    <= 1'b0;
      out_valid_q <= 1'b0;
      out_quot_q  <= '0;
      out_rem_q   <= '0;
      out_dz_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      rem_q       <= rem_d;
      quot_q      <= quot_d;
      bmag_q      <= bmag_d;
      araw_q      <= araw_d;
      sign_a_q    <= sign_a_d;
      sign_b_q    <= sign_b_d;
      out_valid_q <= out_valid_d;
      out_quot_q  <= out_quot_d;
      out_rem_q   <= out_rem_d;
      out_dz_q    <= out_dz_d;
    end
  end

  assign bus.in_ready     = in_ready;
  assign bus.out_valid    = out_valid_q;
  assign bus.out_quot     = out_quot_q;
  assign bus.out_rem      = out_rem_q;
  assign bus.out_div_zero = out_dz_q;

endmodule
`default_nettype wire

// File: tb/tb_lcv_div_seq.sv
`default_nettype none
// ---- tb_lcv_div_seq : directed vectors for lcv_div_seq, WIDTH = 32 -- rev 1.0 ----
module tb_lcv_div_seq;

  localparam int WIDTH = 32;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   vectors = 0;
  int   miscompares = 0;

  lcv_div_seq_if #(.WIDTH(WIDTH)) bus ();

  lcv_div_seq #(.WIDTH(WIDTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Issue one op starting at a negedge, check latency and result, consume it; returns at a negedge.
  task automatic do_op(input string tag, input logic [31:0] a, input logic [31:0] b, input logic s,
                       input logic [31:0] eq, input logic [31:0] er, input logic edz);
    int n;
    bus.in_valid  = 1'b1;
    bus.in_a      = a;
    bus.in_b      = b;
    bus.in_signed = s;
    check({tag, ".in_ready"}, {31'd0, bus.in_ready}, 32'd1);
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    bus.in_a     = 32'hDEAD_BEEF;
    bus.in_b     = 32'h0000_0001;
    n = 0;
    while (!bus.out_valid && n < 40) begin
      @(posedge clk);
      #1;
      n++;
    end
    check({tag, ".latency"}, n, 32'd33);
    check({tag, ".quot"}, bus.out_quot, eq);
    check({tag, ".rem"}, bus.out_rem, er);
    check({tag, ".dz"}, {31'd0, bus.out_div_zero}, {31'd0, edz});
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    check({tag, ".consumed"}, {31'd0, bus.out_valid}, 32'd0);
    check({tag, ".idle"}, {31'd0, bus.in_ready}, 32'd1);
    bus.out_ready = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    int n;
    bus.in_valid  = 1'b0;
    bus.in_a      = '0;
    bus.in_b      = '0;
    bus.in_signed = 1'b0;
    bus.out_ready = 1'b0;

    repeat (3) @(posedge clk);
    #1;
    check("rst.out_valid", {31'd0, bus.out_valid}, 32'd0);
    check("rst.quot", bus.out_quot, 32'd0);
    check("rst.rem", bus.out_rem, 32'd0);
    check("rst.dz", {31'd0, bus.out_div_zero}, 32'd0);
    check("rst.in_ready", {31'd0, bus.in_ready}, 32'd0);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("rst.release_ready", {31'd0, bus.in_ready}, 32'd1);
    @(negedge clk);

    do_op("s100d7",   32'd100,        32'd7,          1'b1, 32'd14,         32'd2,          1'b0);
    do_op("sm100d7",  32'hFFFF_FF9C,  32'd7,          1'b1, 32'hFFFF_FFF2,  32'hFFFF_FFFE,  1'b0);
    do_op("s100dm7",  32'd100,        32'hFFFF_FFF9,  1'b1, 32'hFFFF_FFF2,  32'd2,          1'b0);
    do_op("uffd2",    32'hFFFF_FFFF,  32'd2,          1'b0, 32'h7FFF_FFFF,  32'd1,          1'b0);
    do_op("sm1d2",    32'hFFFF_FFFF,  32'd2,          1'b1, 32'd0,          32'hFFFF_FFFF,  1'b0);
    do_op("s5d0",     32'd5,          32'd0,          1'b1, 32'hFFFF_FFFF,  32'd5,          1'b1);
    do_op("u7d0",     32'd7,          32'd0,          1'b0, 32'hFFFF_FFFF,  32'd7,          1'b1);
    do_op("sovf",     32'h8000_0000,  32'hFFFF_FFFF,  1'b1, 32'h8000_0000,  32'd0,          1'b0);
    do_op("umin",     32'h8000_0000,  32'hFFFF_FFFF,  1'b0, 32'd0,          32'h8000_0000,  1'b0);

    // Backpressure: 20 / 6 held for 10 cycles while a new op is offered.
    bus.in_valid  = 1'b1;
    bus.in_a      = 32'd20;
    bus.in_b      = 32'd6;
    bus.in_signed = 1'b1;
    @(posedge clk);
    #1;
    bus.in_a = 32'd50;
    bus.in_b = 32'd5;
    n = 0;
    while (!bus.out_valid && n < 40) begin
      @(posedge clk);
      #1;
      n++;
    end
    check("bp.latency", n, 32'd33);
    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
      #1;
      check("bp.hold_valid", {31'd0, bus.out_valid}, 32'd1);
      check("bp.hold_quot", bus.out_quot, 32'd3);
      check("bp.hold_rem", bus.out_rem, 32'd2);
      check("bp.in_ready", {31'd0, bus.in_ready}, 32'd0);
    end
    @(negedge clk);
    do_op_after_pulse: begin
      bus.out_ready = 1'b1;
      @(posedge clk);
      #1;
      bus.out_ready = 1'b0;
      check("bp.released", {31'd0, bus.out_valid}, 32'd0);
      @(negedge clk);
    end
    do_op("bp.next", 32'd50, 32'd5, 1'b1, 32'd10, 32'd0, 1'b0);

    // Reset in RUN cycle 10 abandons the op.
    bus.in_valid  = 1'b1;
    bus.in_a      = 32'd1000;
    bus.in_b      = 32'd3;
    bus.in_signed = 1'b0;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    repeat (9) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    check("mid.out_valid", {31'd0, bus.out_valid}, 32'd0);
    check("mid.quot", bus.out_quot, 32'd0);
    check("mid.rem", bus.out_rem, 32'd0);
    check("mid.dz", {31'd0, bus.out_div_zero}, 32'd0);
    check("mid.in_ready", {31'd0, bus.in_ready}, 32'd0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    bus.out_ready = 1'b1;
    do_op("mid.9d3", 32'd9, 32'd3, 1'b0, 32'd3, 32'd0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
